// File: rtl/hazard_pkg.sv
// Shared types for the decode hazard scoreboard: register width, slot record, bubble constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int REG_W          = 3;
    localparam int NUM_REGS       = 1 << REG_W;
    localparam int WB_LAT_DEFAULT = 3;

    // One in-flight destination register; is_load marks a value only known after MEM.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: {REG_W{1'b0}}, is_load: 1'b0};

    // One-hot bitmap position for a register select.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        reg_onehot = NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/decode_hazard_scoreboard_if.sv
// Decode-side register-use bundle plus the scoreboard's stall/issue/status answers.
// Latency: n/a (wires only); stall/issue are combinational, pending/busy registered.
// Backpressure: stall holds PC and IF/ID; flush kills the decode instruction.
interface decode_hazard_scoreboard_if;
    import hazard_pkg::*;

    logic                id_valid;
    logic [REG_W-1:0]    readReg1;
    logic [REG_W-1:0]    readReg2;
    logic                use_rs1;
    logic                use_rs2;
    logic [REG_W-1:0]    writeReg;
    logic                RegWrite;
    logic                MemRead;
    logic                flush;
    logic                stall;
    logic                issue;
    logic [NUM_REGS-1:0] pending;
    logic                busy;

    modport master (
        output id_valid, readReg1, readReg2, use_rs1, use_rs2,
        output writeReg, RegWrite, MemRead, flush,
        input  stall, issue, pending, busy
    );

    modport slave (
        input  id_valid, readReg1, readReg2, use_rs1, use_rs2,
        input  writeReg, RegWrite, MemRead, flush,
        output stall, issue, pending, busy
    );

endinterface

// File: rtl/hazard_slot_cmp.sv
// Compares one tracked slot against both decode sources; reports per-source and load hits.
// Latency: purely combinational.
// Backpressure: none; hits only feed the stall OR-tree.
module hazard_slot_cmp
    import hazard_pkg::*;
(
    input  slot_t            slot_i,
    input  logic [REG_W-1:0] read_reg1_i,
    input  logic [REG_W-1:0] read_reg2_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    output logic             hit1_o,
    output logic             hit2_o,
    output logic             load_hit_o
);

    assign hit1_o     = slot_i.valid & use_rs1_i & (slot_i.rd == read_reg1_i);
    assign hit2_o     = slot_i.valid & use_rs2_i & (slot_i.rd == read_reg2_i);
    assign load_hit_o = slot_i.is_load & (hit1_o | hit2_o);

endmodule

// File: rtl/decode_hazard_scoreboard.sv
// RAW hazard scoreboard beside decode: per-stage slot pipeline EX..WB; macro DECODE_HAZARD_FORWARDING_EN limits stalls to load-use.
// Latency: stall/issue combinational; pending/busy registered one cycle after the edge.
// Backpressure: stall holds decode and inserts a bubble; flush overrides stall and squashes young slots.
module decode_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int WB_LAT      = WB_LAT_DEFAULT,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    decode_hazard_scoreboard_if.slave bus
);

    // The WB slot is not compared: the regfile bypass makes its write visible in decode.
    localparam int CMP_SLOTS = WB_LAT - 1;

    slot_t               slot_q [WB_LAT];
    slot_t               slot_d [WB_LAT];
    logic [CMP_SLOTS-1:0] hit1;
    logic [CMP_SLOTS-1:0] hit2;
    logic [CMP_SLOTS-1:0] load_hit;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                busy_q, busy_d;
    logic                stall_w;
    logic                issue_w;

    for (genvar g = 0; g < CMP_SLOTS; g++) begin : g_cmp
        hazard_slot_cmp u_cmp (
            .slot_i      (slot_q[g]),
            .read_reg1_i (bus.readReg1),
            .read_reg2_i (bus.readReg2),
            .use_rs1_i   (bus.use_rs1),
            .use_rs2_i   (bus.use_rs2),
            .hit1_o      (hit1[g]),
            .hit2_o      (hit2[g]),
            .load_hit_o  (load_hit[g])
        );
    end

`ifdef DECODE_HAZARD_FORWARDING_EN
    // EX/MEM results are forwarded; only a load still in EX cannot supply its value in time.
    assign stall_w = bus.id_valid & ~bus.flush & load_hit[0];
    logic unused_hits;
    assign unused_hits = ^{hit1, hit2, load_hit};
`else
    // Any live match in EX..WB-1 stalls; equal or multiple matches collapse into one stall.
    assign stall_w = bus.id_valid & ~bus.flush & (|{hit1, hit2});
    logic unused_load_hit;
    assign unused_load_hit = ^load_hit;
`endif

    assign issue_w = bus.id_valid & ~stall_w & ~bus.flush;

    // Next slot contents: new entry from decode, unconditional advance, flush squashes young slots.
    always_comb begin
        slot_d[0]         = SLOT_BUBBLE;
        slot_d[0].valid   = issue_w & bus.RegWrite;
        slot_d[0].rd      = bus.writeReg;
        slot_d[0].is_load = bus.MemRead;
        for (int i = 1; i < WB_LAT; i++) begin
            slot_d[i] = slot_q[i-1];
            if (bus.flush && ((i - 1) < FLUSH_SLOTS)) begin
                slot_d[i].valid = 1'b0;
            end
        end
        pending_d = '0;
        busy_d    = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            busy_d = busy_d | slot_d[i].valid;
            if ((i < CMP_SLOTS) && slot_d[i].valid) begin
                pending_d = pending_d | reg_onehot(slot_d[i].rd);
            end
        end
    end

    // Slot pipeline and registered status; reset empties every slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_LAT; i++) begin
                slot_q[i] <= SLOT_BUBBLE;
            end
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            for (int i = 0; i < WB_LAT; i++) begin
                slot_q[i] <= slot_d[i];
            end
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.stall   = stall_w;
    assign bus.issue   = issue_w;
    assign bus.pending = pending_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Bench for decode_hazard_scoreboard: directed vector table, then random traffic against a write-history model.
// Latency: inputs driven at negedge, outputs sampled 1ns later, model advanced at posedge.
// Backpressure: model decides issue from its own stall rule.
module tb_decode_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int WBL = 3;
    localparam int FLS = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_hazard_scoreboard_if dif();

    decode_hazard_scoreboard #(.WB_LAT(WBL), .FLUSH_SLOTS(FLS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        logic       idv;
        logic [2:0] r1, r2;
        logic       u1, u2;
        logic [2:0] wr;
        logic       rw, mr, fl;
        logic       e_stall, e_issue;
        logic [7:0] e_pend;
        logic       e_busy;
    } vec_t;

    // Architectural write history: instruction issued in cycle t writing rd; kill = last cycle it is visible.
    typedef struct {
        int t;
        int rd;
        bit ld;
        int kill;
    } wr_t;

    vec_t tab[$];
    wr_t  hist[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(logic idv, int r1, int r2, logic u1, logic u2, int wr,
                                logic rw, logic mr, logic fl, logic es, logic ei, int ep, logic eb);
        vec_t v;
        v.idv = idv; v.r1 = 3'(r1); v.r2 = 3'(r2); v.u1 = u1; v.u2 = u2; v.wr = 3'(wr);
        v.rw = rw; v.mr = mr; v.fl = fl; v.e_stall = es; v.e_issue = ei; v.e_pend = 8'(ep); v.e_busy = eb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        dif.id_valid = v.idv;  dif.readReg1 = v.r1; dif.readReg2 = v.r2;
        dif.use_rs1  = v.u1;   dif.use_rs2  = v.u2; dif.writeReg = v.wr;
        dif.RegWrite = v.rw;   dif.MemRead  = v.mr; dif.flush    = v.fl;
    endtask

    // A register is unavailable to a reader in cycle c while its producer sits in EX..WB-1.
    function automatic bit m_match(int r, int c);
        foreach (hist[k])
            if (hist[k].rd == r && c >= hist[k].t + 1 && c <= hist[k].t + WBL - 1 && c <= hist[k].kill)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall(vec_t v, int c);
        bit s;
        s = 1'b0;
        if (!v.idv || v.fl) return 1'b0;
`ifdef DECODE_HAZARD_FORWARDING_EN
        foreach (hist[k])
            if (hist[k].ld && hist[k].t == c - 1 && c <= hist[k].kill &&
                ((v.u1 && hist[k].rd == int'(v.r1)) || (v.u2 && hist[k].rd == int'(v.r2))))
                s = 1'b1;
`else
        s = (v.u1 && m_match(int'(v.r1), c)) || (v.u2 && m_match(int'(v.r2), c));
`endif
        return s;
    endfunction

    function automatic logic [7:0] m_pend(int c);
        logic [7:0] p;
        p = '0;
        for (int r = 0; r < 8; r++) p[r] = m_match(r, c);
        return p;
    endfunction

    function automatic logic m_busy(int c);
        foreach (hist[k])
            if (c >= hist[k].t + 1 && c <= hist[k].t + WBL && c <= hist[k].kill) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vec_t v;
        logic es, ei;

        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        #12;
        chk("reset_stall", 32'(dif.stall), 32'd0);
        chk("reset_pending", 32'(dif.pending), 32'd0);
        chk("reset_busy", 32'(dif.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DECODE_HAZARD_FORWARDING_EN
        tab.push_back(mk(1,0,0,0,0,2,1,1,0, 0,1,'h00,0)); // LD r2
        tab.push_back(mk(1,2,0,1,0,4,1,0,0, 1,0,'h04,1)); // use r2: one bubble
        tab.push_back(mk(1,2,0,1,0,4,1,0,0, 0,1,'h04,1));
        tab.push_back(mk(1,0,0,0,0,3,1,0,0, 0,1,'h10,1)); // ALU r3
        tab.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,'h18,1)); // use r3: forwarded
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h08,1));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h00,1));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h00,0));
`else
        tab.push_back(mk(1,0,0,0,0,3,1,0,0, 0,1,'h00,0)); // ADD r3
        tab.push_back(mk(1,3,0,1,0,4,1,0,0, 1,0,'h08,1)); // ADD r4<-r3 stalls twice
        tab.push_back(mk(1,3,0,1,0,4,1,0,0, 1,0,'h08,1));
        tab.push_back(mk(1,3,0,1,0,4,1,0,0, 0,1,'h00,1));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h10,1));
        tab.push_back(mk(1,0,0,0,0,5,1,1,0, 0,1,'h10,1)); // LD r5
        tab.push_back(mk(1,4,5,1,0,0,0,0,0, 0,1,'h20,1)); // r4 in WB only; r5 unused source
        tab.push_back(mk(1,0,0,0,0,1,1,0,0, 0,1,'h20,1)); // SUB r1
        tab.push_back(mk(1,1,1,1,1,0,0,0,0, 1,0,'h02,1)); // store reads r1 twice
        tab.push_back(mk(1,1,1,1,1,0,0,0,0, 1,0,'h02,1));
        tab.push_back(mk(1,1,1,1,1,0,0,0,0, 0,1,'h00,1));
        tab.push_back(mk(1,0,0,0,0,6,1,0,0, 0,1,'h00,0)); // store left no slot
        tab.push_back(mk(1,6,0,1,0,2,1,0,1, 0,0,'h40,1)); // flush over stall
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h00,0)); // r6 squashed
        tab.push_back(mk(1,7,0,1,0,7,1,0,0, 0,1,'h00,0)); // ADDI r7,r7
        tab.push_back(mk(1,7,7,0,0,0,0,0,0, 0,1,'h80,1)); // sources not consumed
        tab.push_back(mk(0,7,0,1,0,0,0,0,0, 0,0,'h80,1)); // no instruction
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h00,1));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,'h00,0));
`endif

        foreach (tab[i]) begin
            drive(tab[i]);
            #1;
            chk($sformatf("tab%0d_stall", i), 32'(dif.stall), 32'(tab[i].e_stall));
            chk($sformatf("tab%0d_issue", i), 32'(dif.issue), 32'(tab[i].e_issue));
            chk($sformatf("tab%0d_pending", i), 32'(dif.pending), 32'(tab[i].e_pend));
            chk($sformatf("tab%0d_busy", i), 32'(dif.busy), 32'(tab[i].e_busy));
            @(posedge clk);
            @(negedge clk);
        end

        hist.delete();
        cyc = 0;
        for (int it = 0; it < 2000; it++) begin
            v = mk($urandom_range(0,3) != 0, $urandom_range(0,7), $urandom_range(0,7),
                   1'($urandom_range(0,1)), 1'($urandom_range(0,1)), $urandom_range(0,7),
                   1'($urandom_range(0,1)), 1'($urandom_range(0,1)), $urandom_range(0,7) == 0,
                   0, 0, 0, 0);
            drive(v);
            #1;
            es = m_stall(v, cyc);
            ei = v.idv & ~es & ~v.fl;
            chk("rnd_stall", 32'(dif.stall), 32'(es));
            chk("rnd_issue", 32'(dif.issue), 32'(ei));
            chk("rnd_pending", 32'(dif.pending), 32'(m_pend(cyc)));
            chk("rnd_busy", 32'(dif.busy), 32'(m_busy(cyc)));
            if (it == 700 || it == 1400) begin
                rst_n = 1'b0;
                #1;
                chk("arst_pending", 32'(dif.pending), 32'd0);
                chk("arst_busy", 32'(dif.busy), 32'd0);
                chk("arst_stall", 32'(dif.stall), 32'd0);
                hist.delete();
                @(posedge clk);
                cyc++;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            @(posedge clk);
            if (v.fl)
                foreach (hist[k])
                    if (hist[k].t >= cyc - FLS && hist[k].t <= cyc - 1 && hist[k].kill > cyc)
                        hist[k].kill = cyc;
            if (ei && v.rw) hist.push_back('{cyc, int'(v.wr), v.mr, 1 << 30});
            cyc++;
            while (hist.size() > 0 && hist[0].t + WBL < cyc) void'(hist.pop_front());
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
